// File: rtl/spi_flash_arbiter.sv
// Round-robin arbiter sharing one SPI flash between instruction-fetch and data-load ports.
// Each grant runs a mode-0 READ: command, 24-bit address, 32 data bits returned as a little-endian word.
module spi_flash_arbiter #(
    parameter int          SCK_DIV  = 1,
    parameter int          CS_GAP   = 2,
    parameter logic [7:0]  READ_CMD = 8'h03
) (
    input  logic        CLK_CPU,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [23:0] if_addr,
    output logic        if_ack,
    input  logic        ld_req,
    input  logic [23:0] ld_addr,
    output logic        ld_ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        SPI_CS,
    output logic        SPI_SCK,
    output logic        SPI_SI,
    input  logic        SPI_SO
);

    localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LOAD = DW'(SCK_DIV - 1);
    // The IDLE cycle that follows DONE already keeps CS high, so only the remainder is spent in GAP.
    localparam int GAP_N = (CS_GAP > 2) ? (CS_GAP - 3) : 0;
    localparam int GW = (GAP_N > 1) ? $clog2(GAP_N + 1) : 1;
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE,
        S_GAP
    } state_t;

    state_t        r_state;
    logic [63:0]   r_sh;
    logic [31:0]   r_rx;
    logic [5:0]    r_bit;
    logic [DW-1:0] r_div;
    logic [GW-1:0] r_gap;
    logic          r_gnt_if;
    logic          r_last_if;
    logic          r_cs;
    logic          r_sck;
    logic          r_if_ack;
    logic          r_ld_ack;
    logic [31:0]   r_rdata;
    logic          r_busy;

    logic          w_pick_if;
    logic [23:0]   w_addr;

    assign w_pick_if = if_req & (~ld_req | ~r_last_if);
    assign w_addr    = w_pick_if ? if_addr : ld_addr;

    always_ff @(posedge CLK_CPU or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_sh      <= '0;
            r_rx      <= '0;
            r_bit     <= '0;
            r_div     <= '0;
            r_gap     <= '0;
            r_gnt_if  <= 1'b0;
            r_last_if <= 1'b0;
            r_cs      <= 1'b1;
            r_sck     <= 1'b0;
            r_if_ack  <= 1'b0;
            r_ld_ack  <= 1'b0;
            r_rdata   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_if_ack <= 1'b0;
            r_ld_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (if_req || ld_req) begin
                        r_gnt_if  <= w_pick_if;
                        r_last_if <= w_pick_if;
                        r_sh      <= {READ_CMD, w_addr, 32'h0};
                        r_bit     <= '0;
                        r_div     <= DIV_LOAD;
                        r_cs      <= 1'b0;
                        r_sck     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_div != '0) begin
                        r_div <= r_div - 1'b1;
                    end else begin
                        r_div <= DIV_LOAD;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                            if (r_bit[5]) begin
                                r_rx <= {r_rx[30:0], SPI_SO};
                            end
                        end else if (r_bit == 6'd63) begin
                            r_sck    <= 1'b0;
                            r_cs     <= 1'b1;
                            r_sh     <= '0;
                            r_rdata  <= {r_rx[7:0], r_rx[15:8], r_rx[23:16], r_rx[31:24]};
                            r_if_ack <= r_gnt_if;
                            r_ld_ack <= ~r_gnt_if;
                            r_state  <= S_DONE;
                        end else begin
                            // MOSI advances only on the falling SCK edge so it is stable at the rise.
                            r_sck <= 1'b0;
                            r_bit <= r_bit + 1'b1;
                            r_sh  <= {r_sh[62:0], 1'b0};
                        end
                    end
                end
                S_DONE: begin
                    if (CS_GAP > 2) begin
                        r_gap   <= GAP_LOAD;
                        r_state <= S_GAP;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_GAP: begin
                    if (r_gap == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign SPI_CS  = r_cs;
    assign SPI_SCK = r_sck;
    assign SPI_SI  = r_sh[63];
    assign if_ack  = r_if_ack;
    assign ld_ack  = r_ld_ack;
    assign rdata   = r_rdata;
    assign busy    = r_busy;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Directed bench for spi_flash_arbiter: two instances (SCK_DIV=1 and 3), each with a behavioural READ-only flash.
module tb_spi_flash_arbiter;

    logic        clk;
    logic        resetn;
    int          cyc;
    int          n_tot;
    int          n_bad;

    logic        if_req, ld_req, if_ack, ld_ack, busy0;
    logic [23:0] if_addr, ld_addr;
    logic [31:0] rdata;
    logic        cs0, sck0, si0, so0;

    logic        if3_req, ld3_req, if3_ack, ld3_ack, busy3;
    logic [23:0] if3_addr, ld3_addr;
    logic [31:0] rdata3;
    logic        cs3, sck3, si3, so3;

    spi_flash_arbiter #(.SCK_DIV(1), .CS_GAP(2), .READ_CMD(8'h03)) dut (
        .CLK_CPU(clk), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack),
        .rdata(rdata), .busy(busy0),
        .SPI_CS(cs0), .SPI_SCK(sck0), .SPI_SI(si0), .SPI_SO(so0)
    );

    spi_flash_arbiter #(.SCK_DIV(3), .CS_GAP(2), .READ_CMD(8'h03)) dut3 (
        .CLK_CPU(clk), .resetn(resetn),
        .if_req(if3_req), .if_addr(if3_addr), .if_ack(if3_ack),
        .ld_req(ld3_req), .ld_addr(ld3_addr), .ld_ack(ld3_ack),
        .rdata(rdata3), .busy(busy3),
        .SPI_CS(cs3), .SPI_SCK(sck3), .SPI_SI(si3), .SPI_SO(so3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] fbyte(input logic [23:0] a);
        case (a)
            24'h000100: return 8'h13;
            24'h000101: return 8'h00;
            24'h000102: return 8'h00;
            24'h000103: return 8'h93;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic dbit(input logic [23:0] a, input int i);
        logic [7:0] b;
        b = fbyte(a + 24'(i / 8));
        return b[7 - (i % 8)];
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {fbyte(a + 24'd3), fbyte(a + 24'd2), fbyte(a + 24'd1), fbyte(a)};
    endfunction

    // Flash models: capture command+address on SCK rise, drive data on SCK fall.
    int          f0_cnt = 0;
    logic [31:0] f0_hdr = '0;
    initial so0 = 1'b0;
    always @(posedge sck0 or posedge cs0) begin
        if (cs0) f0_cnt <= 0;
        else begin
            if (f0_cnt < 32) f0_hdr <= {f0_hdr[30:0], si0};
            f0_cnt <= f0_cnt + 1;
        end
    end
    always @(negedge sck0) if (!cs0 && f0_cnt >= 32 && f0_cnt < 64) so0 <= dbit(f0_hdr[23:0], f0_cnt - 32);

    int          f3_cnt = 0;
    logic [31:0] f3_hdr = '0;
    initial so3 = 1'b0;
    always @(posedge sck3 or posedge cs3) begin
        if (cs3) f3_cnt <= 0;
        else begin
            if (f3_cnt < 32) f3_hdr <= {f3_hdr[30:0], si3};
            f3_cnt <= f3_cnt + 1;
        end
    end
    always @(negedge sck3) if (!cs3 && f3_cnt >= 32 && f3_cnt < 64) so3 <= dbit(f3_hdr[23:0], f3_cnt - 32);

    // SCK phase lengths and MOSI stability on the slow instance.
    logic p_sck3 = 1'b0, p_si3 = 1'b0, p_cs3 = 1'b1;
    int   run3 = 0, si_viol = 0, run_bad = 0, run_seen = 0;
    always @(negedge clk) begin
        if (!cs3 && !p_cs3 && sck3 && p_sck3 && si3 !== p_si3) si_viol <= si_viol + 1;
        if (!cs3) begin
            if (!p_cs3 && sck3 == p_sck3) run3 <= run3 + 1;
            else begin
                if (!p_cs3) begin
                    run_seen <= run_seen + 1;
                    if (run3 != 3) run_bad <= run_bad + 1;
                end
                run3 <= 1;
            end
        end
        p_sck3 <= sck3;
        p_si3  <= si3;
        p_cs3  <= cs3;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ack(input bit want_if, input int c0, input logic [23:0] a, input string tag);
        int lat;
        bit other;
        lat = -1;
        other = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (want_if ? ld_ack : if_ack) other = 1'b1;
            if (want_if ? if_ack : ld_ack) begin
                lat = cyc - c0;
                break;
            end
        end
        chk({tag, "_lat"}, lat, 32'd129);
        chk({tag, "_other_ack"}, {31'd0, other}, 32'd0);
        chk({tag, "_rdata"}, rdata, exp_word(a));
        chk({tag, "_hdr"}, f0_hdr, {8'h03, a});
    endtask

    initial begin
        int c0, d, n, lat3;
        bit seen;
        cyc = 0; n_tot = 0; n_bad = 0;
        resetn = 1'b0;
        if_req = 1'b0; ld_req = 1'b0; if_addr = '0; ld_addr = '0;
        if3_req = 1'b0; ld3_req = 1'b0; if3_addr = '0; ld3_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_cs", {31'd0, cs0}, 32'd1);
        chk("rst_sck", {31'd0, sck0}, 32'd0);
        chk("rst_si", {31'd0, si0}, 32'd0);
        chk("rst_acks", {30'd0, if_ack, ld_ack}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Simultaneous requests straight after reset: fetch first, load after the gap.
        if_addr = 24'h000000; ld_addr = 24'h010000; if_req = 1'b1; ld_req = 1'b1; c0 = cyc;
        wait_ack(1'b1, c0, 24'h000000, "pair1_if");
        if_req = 1'b0; d = cyc;
        @(negedge clk);
        chk("pair1_if_pulse", {31'd0, if_ack}, 32'd0);
        wait_ack(1'b0, d + 1, 24'h010000, "pair1_ld");
        ld_req = 1'b0;
        @(negedge clk);
        chk("pair1_ld_pulse", {31'd0, ld_ack}, 32'd0);

        // Single fetch with a known instruction word.
        if_addr = 24'h000100; if_req = 1'b1; c0 = cyc;
        wait_ack(1'b1, c0, 24'h000100, "fetch");
        if_req = 1'b0;
        chk("fetch_word", rdata, 32'h93000013);
        @(negedge clk);
        chk("fetch_pulse", {31'd0, if_ack}, 32'd0);
        chk("fetch_idle_busy", {31'd0, busy0}, 32'd0);

        // Last grant was fetch, so a simultaneous pair goes load-first; load address wraps.
        if_addr = 24'h000010; ld_addr = 24'hFFFFFE; if_req = 1'b1; ld_req = 1'b1; c0 = cyc;
        wait_ack(1'b0, c0, 24'hFFFFFE, "pair2_ld");
        ld_req = 1'b0; d = cyc;
        @(negedge clk);
        wait_ack(1'b1, d + 1, 24'h000010, "pair2_if");
        if_req = 1'b0;
        @(negedge clk);

        // Held fetch request: CS gap between back-to-back transactions.
        if_addr = 24'h000020; if_req = 1'b1; c0 = cyc;
        wait_ack(1'b1, c0, 24'h000020, "b2b_1");
        d = cyc; n = 0;
        for (int i = 0; i < 10 && cs0; i++) begin
            n++;
            @(negedge clk);
        end
        chk("cs_gap", n, 32'd2);
        wait_ack(1'b1, d + 1, 24'h000020, "b2b_2");
        if_req = 1'b0;
        @(negedge clk);
        chk("b2b_pulse", {31'd0, if_ack}, 32'd0);

        // Load request dropped at bit 10 still completes.
        ld_addr = 24'h000400; ld_req = 1'b1; c0 = cyc;
        for (int i = 0; i < 40 && cyc < c0 + 21; i++) @(negedge clk);
        ld_req = 1'b0;
        chk("drop_busy", {31'd0, busy0}, 32'd1);
        wait_ack(1'b0, c0, 24'h000400, "drop");
        @(negedge clk);
        chk("drop_pulse", {31'd0, ld_ack}, 32'd0);
        chk("drop_idle_busy", {31'd0, busy0}, 32'd0);

        // Asynchronous reset during bit 40 of a load.
        ld_addr = 24'h123456; ld_req = 1'b1; c0 = cyc;
        for (int i = 0; i < 200 && cyc < c0 + 82; i++) @(negedge clk);
        chk("abort_pre_cs", {31'd0, cs0}, 32'd0);
        #2 resetn = 1'b0;
        #1;
        chk("abort_cs", {31'd0, cs0}, 32'd1);
        chk("abort_sck", {31'd0, sck0}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_busy", {31'd0, busy0}, 32'd0);
        ld_req = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (ld_ack || if_ack) seen = 1'b1;
        end
        chk("abort_no_ack", {31'd0, seen}, 32'd0);
        if_addr = 24'h000200; ld_addr = 24'h000300; if_req = 1'b1; ld_req = 1'b1; c0 = cyc;
        wait_ack(1'b1, c0, 24'h000200, "post_rst_if");
        if_req = 1'b0; d = cyc;
        @(negedge clk);
        wait_ack(1'b0, d + 1, 24'h000300, "post_rst_ld");
        ld_req = 1'b0;
        @(negedge clk);

        // Slow SCK instance.
        if3_addr = 24'h000100; if3_req = 1'b1; c0 = cyc; lat3 = -1; seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (ld3_ack) seen = 1'b1;
            if (if3_ack) begin
                lat3 = cyc - c0;
                break;
            end
        end
        if3_req = 1'b0;
        chk("div3_lat", lat3, 32'd385);
        chk("div3_rdata", rdata3, 32'h93000013);
        chk("div3_hdr", f3_hdr, 32'h03000100);
        chk("div3_ld_ack", {31'd0, seen}, 32'd0);
        @(negedge clk);
        chk("div3_pulse", {31'd0, if3_ack}, 32'd0);
        chk("div3_si_stable", si_viol, 32'd0);
        chk("div3_phase_len", run_bad, 32'd0);
        chk("div3_phase_cnt", run_seen, 32'd127);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_arbiter.md
Name: spi_flash_arbiter

Overview:
Shares the single SPI flash between the CPU instruction-fetch port and the data-load port. It arbitrates round-robin and runs a standard READ (0x03) transaction per grant: 8-bit command, 24-bit address, 32 data bits. The assembled little-endian word is returned to the granted requester. It sits between the CPU and the SPI_SS/SPI_SCK/SPI_IO0/SPI_IO1 board pins and runs on CLK_CPU.

Parameters:
SCK_DIV, 1, SCK half-period in CLK_CPU cycles (>=1); SCK period = 2*SCK_DIV cycles
CS_GAP, 2, minimum CLK_CPU cycles SPI_CS stays high between transactions (>=1)
READ_CMD, 8'h03, command byte shifted out first

Ports:
CLK_CPU  input  1  clock; all logic on rising edge
resetn  input  1  asynchronous active-low reset
if_req  input  1  instruction-fetch request; held with if_addr until if_ack
if_addr  input  24  instruction-fetch byte address
if_ack  output  1  one-cycle pulse; rdata valid for fetch
ld_req  input  1  data-load request; held with ld_addr until ld_ack
ld_addr  input  24  data-load byte address
ld_ack  output  1  one-cycle pulse; rdata valid for load
rdata  output  32  last read word, held until next completion
busy  output  1  high from grant through end of CS gap
SPI_CS  output  1  flash chip select, active low
SPI_SCK  output  1  SPI clock, mode 0 (idle low)
SPI_SI  output  1  MOSI to flash
SPI_SO  input  1  MISO from flash

Behaviour:
- Reset (async, resetn=0): SPI_CS=1, SPI_SCK=0, SPI_SI=0, if_ack=0, ld_ack=0, rdata=0, busy=0, state IDLE, last_grant=LD. Applies immediately, including mid-transaction. The aborted transaction gets no ack.
- States: IDLE -> SHIFT -> DONE -> GAP -> IDLE.
- IDLE: if any req is sampled, grant.
  - Only one request: grant it.
  - Both requests: grant the one that is not last_grant. After reset, IF wins first.
  - On grant: latch the address, load the 64-bit shift register {READ_CMD, addr, 32'h0}, update last_grant, set busy=1.
  - Next cycle: SPI_CS=0, state SHIFT, SPI_SI = shift MSB.
- SHIFT: 64 bits, bit counter 0..63.
  - Each bit: SCK low for SCK_DIV cycles, then high for SCK_DIV cycles.
  - SPI_SI changes only while SCK is low (on the edge that drives SCK low, or on SHIFT entry).
  - SPI_SO is sampled on the CLK_CPU edge that drives SCK high, for bits 32..63 only.
  - After the SCK-high phase of bit 63, go to DONE with SCK=0.
- DONE (1 cycle):
  - SPI_CS=1.
  - rdata = {byte3, byte2, byte1, byte0}, where byte0 is the first received byte and each byte is assembled MSB-first.
  - Pulse the granted requester's ack for exactly one cycle; the other ack stays 0.
- GAP: hold SPI_CS=1 for CS_GAP cycles including the DONE cycle, then return to IDLE with busy=0.
- Latency: ack is asserted exactly 1 + 128*SCK_DIV cycles after the IDLE cycle in which the request was sampled.
- Requests are never accepted outside IDLE.
  - A req dropped mid-transaction still completes and still pulses ack.
  - A requester may keep req high through its ack cycle to request again. Round-robin still applies, so a waiting other requester wins.
- No address alignment enforcement; addr wraps at 24 bits per flash behaviour. The block does no address arithmetic.
- rdata is unchanged except in DONE.

Test Plan:
- Single fetch, SCK_DIV=1, flash model bytes at 0x000100 = 13,00,00,93; if_req with if_addr=0x000100 -> SI carries 0x03,0x00,0x01,0x00 MSB-first; if_ack pulses 129 cycles after sampling; rdata=0x93000013; ld_ack stays 0.
- Simultaneous if_req and ld_req after reset (addrs 0x000000 / 0x010000) -> fetch served first, then load after the CS gap; the next simultaneous pair is served load-first only if last_grant=IF; both acks single-cycle.
- Back-to-back held if_req with CS_GAP=2 -> SPI_CS high for exactly 2 cycles between transactions; second CS low follows immediately.
- SCK_DIV=3 -> SCK high/low phases 3 cycles each; SI is stable across each rising SCK edge; ack at 385 cycles.
- resetn pulsed low at bit 40 of a load -> SPI_CS=1 and SCK=0 asynchronously; no ld_ack; rdata=0; next request after release starts a fresh 0x03 command.
- ld_req dropped at bit 10 -> transaction completes, ld_ack pulses, rdata updated, arbiter returns to IDLE.
